// File: rtl/axis_switch_arbiter.sv
// Round-robin AXI-Stream arbiter: merges NUM_SLAVES inputs onto one registered output,
// holding the grant for a whole packet and tagging every beat with its source index.
module axis_switch_arbiter #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 2,
    parameter bit HAS_LAST   = 1'b1
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_SLAVES-1:0]            s_valid,
    output logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_dest,
    input  logic [NUM_SLAVES-1:0]            s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic                             m_last
);
    localparam int GW = $clog2(NUM_SLAVES);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [DEST_WIDTH-1:0]   m_dest_q, m_dest_d;
    logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
    logic                    m_last_q, m_last_d;

    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DEST_WIDTH-1:0]   sel_dest;

    logic                    arb_found;
    logic                    hi_found;
    logic [GW-1:0]           hi_idx;
    logic [GW-1:0]           lo_idx;
    logic [GW-1:0]           arb_idx;

    logic                    out_free;
    logic                    xfer;
    logic                    release_pkt;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_dest  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dest  = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
            end
        end
    end

    // Round-robin search split in two passes: the lowest valid index at or above
    // rr_ptr wins, otherwise the search wraps to the lowest valid index overall.
    always_comb begin
        arb_found = 1'b0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (s_valid[i]) begin
                arb_found = 1'b1;
                lo_idx    = GW'(i);
                if (GW'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(i);
                end
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
    end

    assign out_free    = !m_valid_q || m_ready;
    assign xfer        = (state_q == LOCKED) && sel_valid && out_free;
    assign release_pkt = xfer && (!HAS_LAST || sel_last);

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_ready[i] = (state_q == LOCKED) && (grant_q == GW'(i)) && out_free;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_dest_d  = m_dest_q;
        m_id_d    = m_id_q;
        m_last_d  = m_last_q;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == GW'(NUM_SLAVES - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A drain and a load in the same cycle keep m_valid high with the new beat.
        if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_dest_d  = sel_dest;
            m_id_d    = ID_WIDTH'(grant_q);
            m_last_d  = HAS_LAST && sel_last;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of the others. The output datapath is reset too,
    // because m_data/m_dest/m_id/m_last must read zero while reset is asserted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_dest_q  <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_dest_q  <= m_dest_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_dest  = m_dest_q;
    assign m_id    = m_id_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_axis_switch_arbiter.sv
// Scoreboard bench for axis_switch_arbiter: a 4-input packet-locked instance and a
// 3-input single-beat (HAS_LAST=0) instance, both driven from per-input beat queues.
module tb_axis_switch_arbiter;

    typedef struct {
        logic [63:0] data;
        logic        dest;
        logic        last;
        int          gap;
    } src_beat_t;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        logic        dest;
        logic        last;
    } exp_beat_t;

    logic         aclk   = 1'b0;
    logic         areset = 1'b1;

    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [255:0] s_data;
    logic [3:0]   s_dest;
    logic [3:0]   s_last;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic         m_dest;
    logic [1:0]   m_id;
    logic         m_last;

    logic [2:0]   s2_valid;
    logic [2:0]   s2_ready;
    logic [191:0] s2_data;
    logic [2:0]   s2_dest;
    logic [2:0]   s2_last;
    logic         m2_valid;
    logic         m2_ready;
    logic [63:0]  m2_data;
    logic         m2_dest;
    logic [1:0]   m2_id;
    logic         m2_last;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    src_beat_t src_q[7][$];
    int        gap_left[7];
    logic [6:0] acc;

    exp_beat_t exp1[$];
    exp_beat_t exp2[$];
    int        pops1 = 0;
    int        pops2 = 0;
    int        pop_cyc1[$];

    axis_switch_arbiter #(
        .NUM_SLAVES(4), .DATA_WIDTH(64), .DEST_WIDTH(1), .ID_WIDTH(2), .HAS_LAST(1'b1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest),
        .m_id(m_id), .m_last(m_last)
    );

    axis_switch_arbiter #(
        .NUM_SLAVES(3), .DATA_WIDTH(64), .DEST_WIDTH(1), .ID_WIDTH(2), .HAS_LAST(1'b0)
    ) dut2 (
        .aclk(aclk), .areset(areset),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data), .s_dest(s2_dest), .s_last(s2_last),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_dest(m2_dest),
        .m_id(m2_id), .m_last(m2_last)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic push_src(input int src, input logic [63:0] d, input logic last, input int gap);
        src_beat_t b;
        b.data = d;
        b.dest = d[0];
        b.last = last;
        b.gap  = gap;
        src_q[src].push_back(b);
    endtask

    task automatic push_exp(input int dut_sel, input logic [1:0] id, input logic [63:0] d,
                            input logic last);
        exp_beat_t e;
        e.id   = id;
        e.data = d;
        e.dest = d[0];
        e.last = last;
        if (dut_sel == 1) exp1.push_back(e);
        else exp2.push_back(e);
    endtask

    task automatic wait_pops1(input int target);
        int budget = 100;
        while (pops1 < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check("wait_pops1", pops1, target);
    endtask

    task automatic wait_pops2(input int target);
        int budget = 100;
        while (pops2 < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check("wait_pops2", pops2, target);
    endtask

    // Source driver: a queued beat is presented once its gap has elapsed and is
    // retired after the edge at which valid and ready were both high.
    initial begin
        s_valid  = '0;
        s_data   = '0;
        s_dest   = '0;
        s_last   = '0;
        s2_valid = '0;
        s2_data  = '0;
        s2_dest  = '0;
        s2_last  = '0;
        for (int i = 0; i < 7; i++) gap_left[i] = 0;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < 4; i++) acc[i] = s_valid[i] && s_ready[i];
            for (int i = 0; i < 3; i++) acc[4+i] = s2_valid[i] && s2_ready[i];
            @(posedge aclk);
            #1;
            for (int i = 0; i < 7; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    gap_left[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
                end else if (gap_left[i] > 0) begin
                    gap_left[i]--;
                end
            end
            for (int i = 0; i < 4; i++) begin
                s_valid[i] = (src_q[i].size() > 0) && (gap_left[i] == 0);
                if (src_q[i].size() > 0) begin
                    s_data[i*64 +: 64] = src_q[i][0].data;
                    s_dest[i]          = src_q[i][0].dest;
                    s_last[i]          = src_q[i][0].last;
                end
            end
            for (int i = 0; i < 3; i++) begin
                s2_valid[i] = (src_q[4+i].size() > 0) && (gap_left[4+i] == 0);
                if (src_q[4+i].size() > 0) begin
                    s2_data[i*64 +: 64] = src_q[4+i][0].data;
                    s2_dest[i]          = src_q[4+i][0].dest;
                    s2_last[i]          = src_q[4+i][0].last;
                end
            end
        end
    end

    // Monitors: every cycle with m_valid is compared against the scoreboard head,
    // which is retired only when the beat is actually consumed.
    always @(negedge aclk) begin
        if (!areset && m_valid) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m1_unexpected: got id=%0d data=%0h, expected no beat", m_id, m_data);
            end else begin
                check("m1_id", m_id, exp1[0].id);
                check("m1_data", m_data, exp1[0].data);
                check("m1_dest", m_dest, exp1[0].dest);
                check("m1_last", m_last, exp1[0].last);
                if (m_ready) begin
                    void'(exp1.pop_front());
                    pops1++;
                    pop_cyc1.push_back(cyc);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && m2_valid) begin
            if (exp2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m2_unexpected: got id=%0d data=%0h, expected no beat", m2_id, m2_data);
            end else begin
                check("m2_id", m2_id, exp2[0].id);
                check("m2_data", m2_data, exp2[0].data);
                check("m2_dest", m2_dest, exp2[0].dest);
                check("m2_last", m2_last, exp2[0].last);
                if (m2_ready) begin
                    void'(exp2.pop_front());
                    pops2++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int base;
        int p0;

        m_ready  = 1'b1;
        m2_ready = 1'b1;
        areset   = 1'b1;
        tick(3);

        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_id", m_id, 0);
        check("rst_m_last", m_last, 0);
        check("rst2_m_valid", m2_valid, 0);
        areset = 1'b0;
        tick(2);
        check("idle_m_valid", m_valid, 0);
        check("idle_s_ready", s_ready, 0);

        // Single input streaming: input 2, beats A0..A3, first beat 2 cycles after valid.
        t0   = cyc;
        base = pop_cyc1.size();
        p0   = pops1;
        for (int b = 0; b < 4; b++) begin
            push_src(2, 64'hA0 + 64'(b), b == 3, 0);
            push_exp(1, 2'd2, 64'hA0 + 64'(b), b == 3);
        end
        wait_pops1(p0 + 4);
        for (int b = 0; b < 4; b++) check("stream_cycle", pop_cyc1[base+b], t0 + 3 + b);

        // Reset mid-packet with input 1 locked and a beat held in the output register.
        m_ready = 1'b0;
        push_src(1, 64'hB00, 1'b0, 0);
        push_src(1, 64'hB01, 1'b0, 0);
        push_src(1, 64'hB02, 1'b1, 0);
        push_exp(1, 2'd1, 64'hB00, 1'b0);
        for (int k = 0; k < 10 && !m_valid; k++) tick(1);
        tick(1);
        m_ready = 1'b1;
        #1;
        check("pre_rst_m_valid", m_valid, 1);
        check("pre_rst_s_ready", s_ready, 4'b0010);
        areset = 1'b1;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_s_ready", s_ready, 0);
        check("async_rst_m_data", m_data, 0);
        for (int i = 0; i < 7; i++) begin
            src_q[i].delete();
            gap_left[i] = 0;
        end
        exp1.delete();
        tick(2);
        areset = 1'b0;
        tick(1);
        check("post_rst_m_valid", m_valid, 0);
        check("post_rst_m_data", m_data, 0);
        check("post_rst_m_id", m_id, 0);
        check("post_rst_s_ready", s_ready, 0);

        // rr_ptr was 3 before reset; a cleared pointer must grant input 0 before 3.
        p0 = pops1;
        push_src(3, 64'hE30, 1'b1, 0);
        push_src(0, 64'hE00, 1'b1, 0);
        push_exp(1, 2'd0, 64'hE00, 1'b1);
        push_exp(1, 2'd3, 64'hE30, 1'b1);
        wait_pops1(p0 + 2);

        // Round robin: all four inputs hold two 2-beat packets each.
        t0   = cyc;
        base = pop_cyc1.size();
        p0   = pops1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                for (int b = 0; b < 2; b++) begin
                    push_src(i, 64'hC000 + 64'(i * 256 + p * 16 + b), b == 1, 0);
                    push_exp(1, 2'(i), 64'hC000 + 64'(i * 256 + p * 16 + b), b == 1);
                end
            end
        end
        wait_pops1(p0 + 16);
        check("rr_first_cycle", pop_cyc1[base], t0 + 3);
        for (int k = 0; k < 15; k++) begin
            check("rr_spacing", pop_cyc1[base+k+1] - pop_cyc1[base+k], (k % 2 == 0) ? 1 : 2);
        end

        // Backpressure on input 1 for 5 cycles mid-packet.
        p0 = pops1;
        for (int b = 0; b < 4; b++) begin
            push_src(1, 64'hD10 + 64'(b), b == 3, 0);
            push_exp(1, 2'd1, 64'hD10 + 64'(b), b == 3);
        end
        wait_pops1(p0 + 2);
        m_ready = 1'b0;
        tick(2);
        check("bp_m_valid", m_valid, 1);
        check("bp_s_ready", s_ready, 0);
        tick(3);
        m_ready = 1'b1;
        wait_pops1(p0 + 4);

        // Lock hold: input 0 pauses 3 cycles mid-packet while input 3 waits.
        p0 = pops1;
        push_src(0, 64'hF00, 1'b0, 0);
        push_src(0, 64'hF01, 1'b0, 0);
        push_src(0, 64'hF02, 1'b0, 3);
        push_src(0, 64'hF03, 1'b1, 0);
        for (int b = 0; b < 4; b++) push_exp(1, 2'd0, 64'hF00 + 64'(b), b == 3);
        push_exp(1, 2'd3, 64'hF30, 1'b1);
        wait_pops1(p0 + 2);
        push_src(3, 64'hF30, 1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("lock_s_ready3", s_ready[3], 0);
        end
        wait_pops1(p0 + 5);

        // HAS_LAST=0, three inputs: 0 and 2 alternate, m_last forced low.
        push_src(4, 64'hF0, 1'b1, 0);
        push_src(4, 64'hF1, 1'b0, 0);
        push_src(6, 64'hF2, 1'b1, 0);
        push_src(6, 64'hF3, 1'b0, 0);
        push_exp(2, 2'd0, 64'hF0, 1'b0);
        push_exp(2, 2'd2, 64'hF2, 1'b0);
        push_exp(2, 2'd0, 64'hF1, 1'b0);
        push_exp(2, 2'd2, 64'hF3, 1'b0);
        wait_pops2(4);

        tick(3);
        check("exp1_drained", exp1.size(), 0);
        check("exp2_drained", exp2.size(), 0);
        check("end_m_valid", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
